dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words stored (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted before each access (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit, requester presents a transaction.
REQ-006 The block SHALL have port req_we, input, 1 bit, 1 = store word, 0 = load word.
REQ-007 The block SHALL have port req_addr, input, 32 bits, byte address.
REQ-008 The block SHALL have port req_wdata, input, 32 bits, store data.
REQ-009 The block SHALL have port req_ready, output, 1 bit, responder can accept a request this cycle.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit, response is present.
REQ-011 The block SHALL have port rsp_rdata, output, 32 bits, load data.
REQ-012 The block SHALL have port rsp_err, output, 1 bit, transaction was rejected.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit, requester consumes the response.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE and SHALL be a registered-state decode, with no combinational path from rsp_ready.
REQ-016 Acceptance SHALL occur at edge T where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be latched, the counter loaded with WAIT_CYCLES, and the FSM SHALL go to WAIT.
REQ-017 In WAIT, when counter != 0, the counter SHALL decrement; when counter == 0, the access SHALL be performed and the FSM SHALL go to RESP, so that rsp_valid first rises after edge T+WAIT_CYCLES+1.
REQ-018 Error SHALL be flagged when latched addr[1:0] != 0 or word index addr[31:2] >= DEPTH.
REQ-019 On error, no memory write SHALL occur, rsp_rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-020 A valid store SHALL write req_wdata to the word, and its response SHALL carry rsp_rdata = 0 and rsp_err = 0.
REQ-021 A valid load SHALL register the word into rsp_rdata, with rsp_err = 0.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready = 1; the FSM SHALL then go to IDLE, and rsp_valid and rsp_err SHALL clear.
REQ-023 Outside RESP, rsp_valid SHALL be 0; rsp_rdata SHALL retain its last value.
REQ-024 req_valid while req_ready = 0 SHALL be ignored, with no latching.
REQ-025 Back-to-back operation: the minimum transaction period SHALL be WAIT_CYCLES+3 cycles, and a request held from the RESP-exit cycle SHALL be accepted at the following edge.
REQ-026 A load following a store to the same word SHALL return the stored data.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 and req_ready = 1 after release.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction; a pending store that has not reached its access edge SHALL NOT write.
REQ-029 Memory array contents SHALL NOT be cleared by rst.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), DEPTH and WAIT_CYCLES defaults, and the counter width constant (4).
REQ-031 Storage SHALL be a sub-module dmem_array with a synchronous write port and a read port, instantiated once; the FSM, counter and error check SHALL live in dmem_responder.

Verification
REQ-032 Reset-state scenario: after reset -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0x0, rsp_err = 0.
REQ-033 Store/load scenario (WAIT_CYCLES=2): store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid 3 edges after each accept, load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-034 Error scenario: load 0x13 (misaligned) and load 0x100 (DEPTH=64) -> rsp_err = 1, rsp_rdata = 0; a following load of 0x10 still returns 0xDEADBEEF.
REQ-035 Backpressure scenario: hold rsp_ready = 0 for 5 cycles on a load -> rsp_valid and rsp_rdata stable throughout, req_ready = 0, and a new req_valid is ignored.
REQ-036 Mid-operation reset scenario: store 0x12345678 to 0x20, assert rst during WAIT, then load 0x20 -> prior contents returned (not 0x12345678), FSM back in IDLE.
REQ-037 Zero-wait scenario (WAIT_CYCLES=0): continuous requests with rsp_ready = 1 -> rsp_valid one edge after each accept, one transaction per 3 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEF       = 64;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read; never reset so contents survive rst.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with programmable wait states and
// alignment/range checking.
//
// state | meaning
// IDLE  | ready for a request; req_ready = 1
// WAIT  | request latched; down-counter runs, access happens at terminal count
// RESP  | response held on rsp_* until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             accept, access, addr_err, mem_we;
  logic [31:0]      mem_rdata;
  logic [31:0]      rdata_q;
  logic             err_q;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept   = req_valid && req_ready;
  assign access   = (state == WAIT) && (cnt == '0);
  assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  // Rejected stores must never reach the array, even with an aliasing index.
  assign mem_we   = access && lat_we && !addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)       state_next = WAIT;
      WAIT:    if (cnt == '0)    state_next = RESP;
      RESP:    if (rsp_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= CNT_W'(WAIT_CYCLES);
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (access) begin
        err_q   <= addr_err;
        rdata_q <= (addr_err || lat_we) ? 32'h0 : mem_rdata;
      end else if ((state == RESP) && rsp_ready) begin
        err_q <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (lat_addr[AW+1:2]),
    .wdata (lat_wdata),
    .raddr (lat_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_z = 1'b0, req_we_z = 1'b0, rsp_ready_z = 1'b0;
  logic [31:0] req_addr_z = '0, req_wdata_z = '0;
  logic        req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .req_ready(req_ready_z),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .rsp_ready(rsp_ready_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on the WAIT_CYCLES=2 instance; called at posedge+1 in IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #2 rst = 1'b1;
    #1;
    check("in_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    #19 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'h0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("store_latency", 32'(lat), 32'd3);
    check("store_rdata", rd, 32'h0);
    check("store_err", 32'(er), 32'h0);
    check("after_rsp_valid", 32'(rsp_valid), 32'h0);
    check("after_req_ready", 32'(req_ready), 32'h1);

    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("load_latency", 32'(lat), 32'd3);
    check("load_rdata", rd, 32'hDEADBEEF);
    check("load_err", 32'(er), 32'h0);
    check("idle_rdata_retained", rsp_rdata, 32'hDEADBEEF);
    check("idle_err_cleared", 32'(rsp_err), 32'h0);

    txn(1'b0, 32'h13, 32'h0, rd, er, lat);
    check("misalign_err", 32'(er), 32'h1);
    check("misalign_rdata", rd, 32'h0);
    txn(1'b0, 32'h100, 32'h0, rd, er, lat);
    check("range_err", 32'(er), 32'h1);
    check("range_rdata", rd, 32'h0);
    check("range_latency", 32'(lat), 32'd3);

    txn(1'b1, 32'h0, 32'h11111111, rd, er, lat);
    txn(1'b1, 32'h100, 32'hBAD0BAD0, rd, er, lat);
    check("range_store_err", 32'(er), 32'h1);
    txn(1'b1, 32'h12, 32'hBAD1BAD1, rd, er, lat);
    check("misalign_store_err", 32'(er), 32'h1);
    txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("no_alias_write_w0", rd, 32'h11111111);
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("after_err_load", rd, 32'hDEADBEEF);
    check("after_err_load_err", 32'(er), 32'h0);

    // Backpressure: load 0x10 and hold the response while a store is offered.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_rsp_valid_rise", 32'(rsp_valid), 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_exit_rsp_valid", 32'(rsp_valid), 32'h0);
    check("bp_exit_req_ready", 32'(req_ready), 32'h1);
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'hDEADBEEF);

    // Back-to-back: request held from the RESP-exit cycle is accepted next edge.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    check("b2b_first_accepted", 32'(req_ready), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("b2b_first_rsp", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("b2b_idle_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_accepted", 32'(req_ready), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("b2b_second_rsp", 32'(rsp_valid), 32'h1);
    check("b2b_second_rdata", rsp_rdata, 32'hDEADBEEF);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Mid-operation reset abandons a pending store.
    txn(1'b1, 32'h20, 32'hCAFEF00D, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_still_idle", 32'(req_ready), 32'h1);
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("midrst_load_latency", 32'(lat), 32'd3);
    check("midrst_prior_data", rd, 32'hCAFEF00D);

    // Zero-wait instance: continuous requests, one transaction per 3 cycles.
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h8; req_wdata_z = 32'h5A5A5A5A;
    rsp_ready_z = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("zw_rsp_valid", 32'(rsp_valid_z), (i % 3 == 1) ? 32'h1 : 32'h0);
      check("zw_req_ready", 32'(req_ready_z), (i % 3 == 2) ? 32'h1 : 32'h0);
    end
    req_we_z = 1'b0;
    @(posedge clk); #1;
    req_valid_z = 1'b0;
    @(posedge clk); #1;
    check("zw_load_rsp_valid", 32'(rsp_valid_z), 32'h1);
    check("zw_load_rdata", rsp_rdata_z, 32'h5A5A5A5A);
    check("zw_load_err", 32'(rsp_err_z), 32'h0);
    @(posedge clk); #1;
    check("zw_final_idle", 32'(req_ready_z), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
